// File: rtl/t05_sd_block_reader.sv
// t05_sd_block_reader
// Consumes the byte stream of an SD multi-block read (CMD18) coming from the
// SPI stage. It hunts for the 0xFE start token, forwards BLOCK_BYTES payload
// bytes per block into an output FIFO, discards the two CRC bytes, counts
// completed blocks, and raises read_stop so the SPI stage can issue CMD12.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   start, num_blocks      begin a read of num_blocks blocks (sampled on start)
//   byte_in, byte_valid    received byte and its one-cycle strobe
//   data_out, data_valid   FIFO head byte and FIFO-not-empty
//   data_ready             consumer accepts data_out
//   read_stop              request to the SPI stage to send CMD12
//   blocks_done            completed block count
//   busy, done             not-idle flag, one-cycle completion pulse
//   token_err, overrun     sticky error flags, cleared by the next start
module t05_sd_block_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int FIFO_DEPTH    = 16,
  parameter int TOKEN_TIMEOUT = 1024,
  parameter int STOP_HOLD     = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] num_blocks,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        read_stop,
  output logic [15:0] blocks_done,
  output logic        busy,
  output logic        done,
  output logic        token_err,
  output logic        overrun
);

  localparam int BC_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int WC_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam int SC_W = $clog2(STOP_HOLD + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BLOCK_BYTES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TOKEN_TIMEOUT - 1);
  localparam logic [SC_W-1:0] STOP_LAST = SC_W'(STOP_HOLD - 1);
  localparam logic [SC_W-1:0] STOP_MAX  = SC_W'(STOP_HOLD);
  localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TOKEN = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_STOP       = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t          state_r, state_next;
  logic [15:0]     num_r, num_next;
  logic [15:0]     blocks_done_r, blocks_next;
  logic [BC_W-1:0] byte_cnt_r, byte_cnt_next;
  logic [WC_W-1:0] wait_cnt_r, wait_cnt_next;
  logic            crc_cnt_r, crc_cnt_next;
  logic [SC_W-1:0] stop_cnt_r, stop_cnt_next;
  logic            token_err_r, tok_err_next;
  logic            busy_r, read_stop_r, done_r;
  logic            fifo_clr_s, push_req_s;

  // FIFO storage and control
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]   count_r, cnt_after_pop_s, count_next_s;
  logic [7:0]      data_out_r, head_s;
  logic            data_valid_r, overrun_r;
  logic            pop_s, push_s, drop_s;

  // Next-state logic and per-state counter updates.
  always_comb begin
    state_next    = state_r;
    num_next      = num_r;
    blocks_next   = blocks_done_r;
    byte_cnt_next = byte_cnt_r;
    wait_cnt_next = wait_cnt_r;
    crc_cnt_next  = crc_cnt_r;
    stop_cnt_next = {SC_W{1'b0}};
    tok_err_next  = token_err_r;
    fifo_clr_s    = 1'b0;
    push_req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A byte arriving together with start is deliberately ignored here.
        if (start) begin
          num_next      = num_blocks;
          blocks_next   = 16'd0;
          tok_err_next  = 1'b0;
          fifo_clr_s    = 1'b1;
          wait_cnt_next = {WC_W{1'b0}};
          byte_cnt_next = {BC_W{1'b0}};
          crc_cnt_next  = 1'b0;
          if (num_blocks == 16'd0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT_TOKEN;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_TOKEN: begin
        if (byte_valid) begin
          if (byte_in == 8'hFE) begin
            state_next    = ST_DATA;
            byte_cnt_next = {BC_W{1'b0}};
            wait_cnt_next = {WC_W{1'b0}};
          end else if (byte_in == 8'hFF) begin
            if (wait_cnt_r == WAIT_LAST) begin
              tok_err_next = 1'b1;
              state_next   = ST_STOP;
            end else begin
              wait_cnt_next = wait_cnt_r + WC_W'(1);
            end
          end else if (byte_in[7:4] == 4'h0) begin
            // SD data-error token
            tok_err_next = 1'b1;
            state_next   = ST_STOP;
          end else begin
            state_next = ST_WAIT_TOKEN;
          end
        end else begin
          state_next = ST_WAIT_TOKEN;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          push_req_s = 1'b1;
          if (byte_cnt_r == BYTE_LAST) begin
            state_next    = ST_CRC;
            byte_cnt_next = {BC_W{1'b0}};
            crc_cnt_next  = 1'b0;
          end else begin
            byte_cnt_next = byte_cnt_r + BC_W'(1);
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_CRC: begin
        if (byte_valid) begin
          if (crc_cnt_r) begin
            crc_cnt_next  = 1'b0;
            blocks_next   = blocks_done_r + 16'd1;
            wait_cnt_next = {WC_W{1'b0}};
            if ((blocks_done_r + 16'd1) == num_r) begin
              state_next = ST_STOP;
            end else begin
              state_next = ST_WAIT_TOKEN;
            end
          end else begin
            crc_cnt_next = 1'b1;
          end
        end else begin
          state_next = ST_CRC;
        end
      end
      ST_STOP: begin
        // Cycle counter saturates so a slow consumer cannot wrap it.
        if (stop_cnt_r == STOP_MAX) begin
          stop_cnt_next = stop_cnt_r;
        end else begin
          stop_cnt_next = stop_cnt_r + SC_W'(1);
        end
        if ((stop_cnt_r >= STOP_LAST) && (count_r == {CW{1'b0}})) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and the status outputs derived from them.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= ST_IDLE;
      num_r         <= 16'd0;
      blocks_done_r <= 16'd0;
      byte_cnt_r    <= {BC_W{1'b0}};
      wait_cnt_r    <= {WC_W{1'b0}};
      crc_cnt_r     <= 1'b0;
      stop_cnt_r    <= {SC_W{1'b0}};
      token_err_r   <= 1'b0;
      busy_r        <= 1'b0;
      read_stop_r   <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_next;
      num_r         <= num_next;
      blocks_done_r <= blocks_next;
      byte_cnt_r    <= byte_cnt_next;
      wait_cnt_r    <= wait_cnt_next;
      crc_cnt_r     <= crc_cnt_next;
      stop_cnt_r    <= stop_cnt_next;
      token_err_r   <= tok_err_next;
      // busy and read_stop track the state they describe, cycle for cycle.
      busy_r        <= (state_next != ST_IDLE);
      read_stop_r   <= (state_next == ST_STOP);
      // done is registered off the DONE state, so it pulses as the FSM
      // returns to IDLE: two cycles after a start with num_blocks == 0.
      done_r        <= (state_r == ST_DONE);
    end
  end

  // FIFO push/pop decisions and the value the head register takes next.
  always_comb begin
    pop_s  = data_valid_r && data_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_s = push_req_s && ((count_r != FIFO_FULL) || pop_s);
    drop_s = push_req_s && !push_s;
    cnt_after_pop_s = count_r - {{(CW-1){1'b0}}, pop_s};
    count_next_s    = cnt_after_pop_s + {{(CW-1){1'b0}}, push_s};
    rd_next_s       = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
    if (count_next_s == {CW{1'b0}}) begin
      head_s = 8'h00;
    end else if (cnt_after_pop_s == {CW{1'b0}}) begin
      // The only remaining entry is the one being written right now.
      head_s = byte_in;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage, pointers, registered head and overrun flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (fifo_clr_s) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= byte_in;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      data_out_r   <= head_s;
      data_valid_r <= (count_next_s != {CW{1'b0}});
      overrun_r    <= overrun_r | drop_s;
    end
  end

  assign data_out    = data_out_r;
  assign data_valid  = data_valid_r;
  assign read_stop   = read_stop_r;
  assign blocks_done = blocks_done_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign token_err   = token_err_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_t05_sd_block_reader.sv
// Directed testbench for t05_sd_block_reader with default parameters.
module tb_t05_sd_block_reader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] num_blocks;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        read_stop;
  logic [15:0] blocks_done;
  logic        busy;
  logic        done;
  logic        token_err;
  logic        overrun;

  t05_sd_block_reader dut (
    .clk(clk), .nrst(nrst), .start(start), .num_blocks(num_blocks),
    .byte_in(byte_in), .byte_valid(byte_valid), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .read_stop(read_stop),
    .blocks_done(blocks_done), .busy(busy), .done(done),
    .token_err(token_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Monitor: consumed bytes, done pulses and read_stop-high cycles.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int done_cnt = 0;
  int stop_cycles = 0;
  always @(posedge clk) begin
    if (nrst && data_valid && data_ready) rx_q.push_back(data_out);
    if (done) done_cnt <= done_cnt + 1;
    if (read_stop) stop_cycles <= stop_cycles + 1;
  end

  function automatic int count_mism(input int base, input int n);
    int m = 0;
    for (int i = 0; i < n; i++) begin
      if ((base + i) >= rx_q.size()) m++;
      else if (rx_q[base + i] !== exp_q[i]) m++;
    end
    return m;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; data_ready = rdy;
  endtask

  task automatic idle_byte();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; num_blocks = n; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done_wait: done never seen within 3000 cycles, required 1", tag);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; num_blocks = 16'd0; byte_in = 8'h00;
    byte_valid = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({data_out, data_valid, read_stop, blocks_done, busy, done, token_err, overrun} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0",
               {data_out, data_valid, read_stop, blocks_done, busy, done, token_err, overrun});
    end
    nrst = 1'b1;
  endtask

  task automatic test_single_block();
    int rx_base = rx_q.size();
    int d0 = done_cnt;
    int s0 = stop_cycles;
    int m;
    pulse_start(16'd1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b1);
    send_byte(8'hFE, 1'b1);
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b = 8'(i);
      exp_q.push_back(b);
      if (i == 100) begin start = 1'b1; num_blocks = 16'd5; end
      send_byte(b, 1'b1);
      start = 1'b0;
    end
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    n_vec++;
    if (read_stop !== 1'b0) begin
      n_err++; $display("FAIL single_stop_early: read_stop=%b before last CRC, required 0", read_stop);
    end
    idle_byte();
    n_vec++;
    if (read_stop !== 1'b1) begin
      n_err++; $display("FAIL single_stop_rise: read_stop=%b after last CRC, required 1", read_stop);
    end
    n_vec++;
    if (blocks_done !== 16'd1) begin
      n_err++; $display("FAIL single_blocks_done: got %0d, required 1", blocks_done);
    end
    wait_done("single");
    @(negedge clk);
    n_vec++;
    if (done_cnt - d0 !== 1) begin
      n_err++; $display("FAIL single_done_pulses: got %0d, required 1", done_cnt - d0);
    end
    n_vec++;
    if (stop_cycles - s0 < 64) begin
      n_err++; $display("FAIL single_stop_hold: read_stop high %0d cycles, required >=64", stop_cycles - s0);
    end
    n_vec++;
    if (rx_q.size() - rx_base !== 512) begin
      n_err++; $display("FAIL single_byte_count: got %0d, required 512", rx_q.size() - rx_base);
    end
    m = count_mism(rx_base, 512);
    n_vec++;
    if (m !== 0) begin
      n_err++; $display("FAIL single_payload: %0d bytes differ, required 0", m);
    end
    n_vec++;
    if ({busy, done, data_valid} !== 3'b000) begin
      n_err++; $display("FAIL single_idle_after: busy/done/valid=%b, required 000", {busy, done, data_valid});
    end
  endtask

  task automatic test_three_blocks();
    int rx_base = rx_q.size();
    int m;
    pulse_start(16'd3);
    exp_q.delete();
    for (int b = 0; b < 3; b++) begin
      if (b != 0) begin send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1); end
      send_byte(8'hFE, 1'b1);
      for (int i = 0; i < 512; i++) begin
        logic [7:0] v = 8'(i * 3 + b * 17);
        exp_q.push_back(v);
        send_byte(v, 1'b1);
      end
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle_byte();
      n_vec++;
      if (blocks_done !== 16'(b + 1)) begin
        n_err++; $display("FAIL multi_blocks_done_%0d: got %0d, required %0d", b, blocks_done, b + 1);
      end
      n_vec++;
      if (read_stop !== (b == 2)) begin
        n_err++; $display("FAIL multi_read_stop_%0d: got %b, required %b", b, read_stop, b == 2);
      end
    end
    wait_done("multi");
    @(negedge clk);
    m = count_mism(rx_base, 1536);
    n_vec++;
    if ((rx_q.size() - rx_base !== 1536) || (m !== 0)) begin
      n_err++; $display("FAIL multi_payload: %0d bytes, %0d differ; required 1536, 0", rx_q.size() - rx_base, m);
    end
  endtask

  task automatic test_overrun();
    int rx_base = rx_q.size();
    int d0;
    int m;
    pulse_start(16'd1);
    exp_q.delete();
    send_byte(8'hFE, 1'b0);
    for (int i = 0; i < 512; i++) begin
      if (i < 16) exp_q.push_back(8'(i + 64));
      send_byte(8'(i + 64), 1'b0);
    end
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    idle_byte();
    n_vec++;
    if ({overrun, data_valid, read_stop} !== 3'b111) begin
      n_err++; $display("FAIL ovr_flags: overrun/valid/stop=%b, required 111", {overrun, data_valid, read_stop});
    end
    n_vec++;
    if (data_out !== 8'd64) begin
      n_err++; $display("FAIL ovr_head: data_out=%h, required 40", data_out);
    end
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    n_vec++;
    if ((busy !== 1'b1) || (done_cnt != d0)) begin
      n_err++; $display("FAIL ovr_stop_waits: busy=%b done_pulses=%0d, required 1 and 0", busy, done_cnt - d0);
    end
    data_ready = 1'b1;
    wait_done("ovr");
    @(negedge clk);
    m = count_mism(rx_base, 16);
    n_vec++;
    if ((rx_q.size() - rx_base !== 16) || (m !== 0)) begin
      n_err++; $display("FAIL ovr_drained: %0d bytes, %0d differ; required 16, 0", rx_q.size() - rx_base, m);
    end
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky: overrun=%b after done, required 1", overrun);
    end
  endtask

  task automatic test_timeout();
    pulse_start(16'd1);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL tmo_ovr_cleared: overrun=%b after start, required 0", overrun);
    end
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 1023; i++) send_byte(8'hFF, 1'b1);
    idle_byte();
    n_vec++;
    if ({token_err, read_stop, busy} !== 3'b001) begin
      n_err++; $display("FAIL tmo_1023: err/stop/busy=%b, required 001", {token_err, read_stop, busy});
    end
    send_byte(8'hFF, 1'b1);
    idle_byte();
    n_vec++;
    if ({token_err, read_stop} !== 2'b11) begin
      n_err++; $display("FAIL tmo_1024: err/stop=%b, required 11", {token_err, read_stop});
    end
    wait_done("tmo");
    @(negedge clk);
    n_vec++;
    if ({token_err, blocks_done} !== {1'b1, 16'd0}) begin
      n_err++; $display("FAIL tmo_after: err=%b blocks=%0d, required 1 and 0", token_err, blocks_done);
    end
  endtask

  task automatic test_error_token();
    // start arrives together with a 0xFE byte, which must be ignored
    @(negedge clk);
    start = 1'b1; num_blocks = 16'd2; byte_in = 8'hFE; byte_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    n_vec++;
    if ({token_err, busy} !== 2'b01) begin
      n_err++; $display("FAIL errtok_start: err/busy=%b, required 01", {token_err, busy});
    end
    send_byte(8'h08, 1'b1);
    idle_byte();
    n_vec++;
    if ({token_err, read_stop} !== 2'b11) begin
      n_err++; $display("FAIL errtok_flag: err/stop=%b, required 11", {token_err, read_stop});
    end
    wait_done("errtok");
  endtask

  task automatic test_zero_blocks();
    int s0 = stop_cycles;
    @(negedge clk);
    start = 1'b1; num_blocks = 16'd0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++; $display("FAIL zero_cycle1: busy/done=%b, required 10", {busy, done});
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b01) begin
      n_err++; $display("FAIL zero_cycle2: busy/done=%b, required 01", {busy, done});
    end
    @(negedge clk);
    n_vec++;
    if ((done !== 1'b0) || (stop_cycles != s0)) begin
      n_err++; $display("FAIL zero_after: done=%b stop_cycles=%0d, required 0 and 0", done, stop_cycles - s0);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(16'd1);
    send_byte(8'hFE, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b0);
    idle_byte();
    n_vec++;
    if ({data_valid, busy} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_before: valid/busy=%b, required 11", {data_valid, busy});
    end
    #2 nrst = 1'b0;
    #1;
    n_vec++;
    if ({data_out, data_valid, read_stop, blocks_done, busy, done, token_err, overrun} !== 30'd0) begin
      n_err++; $display("FAIL rstmid_async: got %h, required 0",
                        {data_out, data_valid, read_stop, blocks_done, busy, done, token_err, overrun});
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int rx_base = rx_q.size();
    int m;
    pulse_start(16'd1);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i * 5 + 3));
    send_byte(8'hFE, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(exp_q[i], 1'b0);
    idle_byte();
    n_vec++;
    if ({data_valid, overrun, data_out} !== {1'b1, 1'b0, exp_q[0]}) begin
      n_err++; $display("FAIL b2b_full: valid=%b ovr=%b head=%h, required 1 0 %h",
                        data_valid, overrun, data_out, exp_q[0]);
    end
    // 100+ cycles of push and pop together on a full FIFO
    for (int i = 16; i < 512; i++) send_byte(exp_q[i], 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    idle_byte();
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL b2b_overrun: overrun=%b, required 0", overrun);
    end
    wait_done("b2b");
    @(negedge clk);
    m = count_mism(rx_base, 512);
    n_vec++;
    if ((rx_q.size() - rx_base !== 512) || (m !== 0)) begin
      n_err++; $display("FAIL b2b_order: %0d bytes, %0d differ; required 512, 0", rx_q.size() - rx_base, m);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_three_blocks();
    test_overrun();
    test_timeout();
    test_error_token();
    test_zero_blocks();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
